whitened_sample_reader: RTL and testbench

- Reads whitened samples Z1..Z4 back out of the RAM2 store after the whitening pipeline has written them.
- Streams them to the downstream ICA iteration core over a valid/ready handshake.
- Sits between the RAM2 read port and the fixed-point ICA update engine.
- Hides the synchronous-RAM read latency with a prefetch buffer, so a continuously-ready consumer receives one sample per clock.

---
 rtl/whitened_sample_reader_if.sv | 29 ++
 rtl/whitened_sample_reader.sv | 124 ++++++++++++
 tb/tb_whitened_sample_reader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/whitened_sample_reader_if.sv
// RAM2 read port and Z-sample stream bundle for the whitened sample reader.
// master = the reader; slave = RAM2 plus the downstream ICA consumer.
interface whitened_sample_reader_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 26
);
  logic                     En_mem;
  logic                     R_w_mem;
  logic [ADDR_W-1:0]        addr_mem;
  logic signed [DATA_W-1:0] q1, q2, q3, q4;
  logic                     Z_valid;
  logic                     Z_ready;
  logic signed [DATA_W-1:0] Z1, Z2, Z3, Z4;
  logic                     Z_last;

  modport master (
    output En_mem, R_w_mem, addr_mem,
    input  q1, q2, q3, q4,
    output Z_valid, Z1, Z2, Z3, Z4, Z_last,
    input  Z_ready
  );

  modport slave (
    input  En_mem, R_w_mem, addr_mem,
    output q1, q2, q3, q4,
    input  Z_valid, Z1, Z2, Z3, Z4, Z_last,
    output Z_ready
  );
endinterface

// File: rtl/whitened_sample_reader.sv
// Streams whitened samples Z1..Z4 out of RAM2 to the ICA core, hiding the
// one-cycle RAM read latency behind a credit-controlled 2-entry prefetch FIFO.
module whitened_sample_reader #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 26,
  parameter int N_SAMPLES = 10000
) (
  input  logic CLK_zread,
  input  logic RST_n,
  input  logic GO_zread,
  input  logic Loop,
  input  logic Abort,
  output logic Zread_busy,
  output logic Zread_done,
  whitened_sample_reader_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] z1;
    logic signed [DATA_W-1:0] z2;
    logic signed [DATA_W-1:0] z3;
    logic signed [DATA_W-1:0] z4;
    logic                     last;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic              infl_last_q, infl_last_d;
  logic [1:0]        cnt_q, cnt_d;
  entry_t            ent0_q, ent0_d, ent1_q, ent1_d;

  logic              issue, pop, push, at_last, flush;
  logic [1:0]        wr_idx;
  entry_t            new_ent;

  // Credit: never have more than two samples issued but not yet accepted.
  always_comb begin
    pop     = (cnt_q != 2'd0) && bus.Z_ready;
    push    = inflight_q;
    at_last = (addr_q == LAST_ADDR);
    flush   = Abort && (state_q != IDLE);
    issue   = (state_q == STREAM) && !Abort &&
              (({1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);
    new_ent = '{z1: bus.q1, z2: bus.q2, z3: bus.q3, z4: bus.q4, last: infl_last_q};
    inflight_d  = issue;
    infl_last_d = issue && at_last;
  end

  // Shift-register FIFO: entry 0 is always the registered head.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    wr_idx = cnt_q - {1'b0, pop};
    if (pop && (cnt_q == 2'd2)) ent0_d = ent1_q;
    if (push) begin
      if (wr_idx == 2'd0) ent0_d = new_ent;
      else                ent1_d = new_ent;
    end
    if (flush) cnt_d = 2'd0;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (GO_zread && !Abort) begin
          addr_d  = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (issue) begin
          if (!at_last)  addr_d  = addr_q + 1'b1;
          else if (Loop) addr_d  = '0;
          else           state_d = DRAIN;
        end
      end
      DRAIN:   if ((cnt_d == 2'd0) && !inflight_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge CLK_zread or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      ent0_q      <= '0;
      ent1_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
    end
  end

  assign bus.En_mem   = issue;
  assign bus.R_w_mem  = 1'b0;
  assign bus.addr_mem = addr_q;
  assign bus.Z_valid  = (cnt_q != 2'd0);
  assign bus.Z1       = ent0_q.z1;
  assign bus.Z2       = ent0_q.z2;
  assign bus.Z3       = ent0_q.z3;
  assign bus.Z4       = ent0_q.z4;
  assign bus.Z_last   = ent0_q.last;
  assign Zread_busy   = (state_q == STREAM) || (state_q == DRAIN);
  assign Zread_done   = (state_q == DONE);

endmodule

// File: tb/tb_whitened_sample_reader.sv
// Scoreboard bench for whitened_sample_reader with N_SAMPLES=8 and a RAM2
// model returning Zk = 16*addr + k one cycle after each read enable.
module tb_whitened_sample_reader;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 26;
  localparam int N      = 8;

  typedef struct {int addr; bit last;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go = 1'b0, loop_i = 1'b0, abort = 1'b0;
  logic busy, done;

  whitened_sample_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  whitened_sample_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SAMPLES(N)) dut (
    .CLK_zread (clk),
    .RST_n     (rst_n),
    .GO_zread  (go),
    .Loop      (loop_i),
    .Abort     (abort),
    .Zread_busy(busy),
    .Zread_done(done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.En_mem) begin
      bus.q1 <= DATA_W'(16 * int'(bus.addr_mem) + 1);
      bus.q2 <= DATA_W'(16 * int'(bus.addr_mem) + 2);
      bus.q3 <= DATA_W'(16 * int'(bus.addr_mem) + 3);
      bus.q4 <= DATA_W'(16 * int'(bus.addr_mem) + 4);
    end
  end

  int   tests = 0, fails = 0;
  exp_t sb[$];
  int   beat_cnt, done_cnt, last_cnt, first_valid_cyc, last_beat_cyc, first_beat_cyc;
  int   done_cyc, first_z1, last_z1, outstanding;
  bit   loop_drop = 1'b0;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat
  bit prev_stall = 1'b0, prev_abort = 1'b0;
  logic [4*DATA_W:0] prev_data;
  always @(negedge clk) begin
    bit pop;
    exp_t e;
    logic [4*DATA_W:0] cur;
    if (!rst_n) begin
      outstanding = 0;
      prev_stall  = 1'b0;
      prev_abort  = 1'b0;
    end else begin
      pop = bus.Z_valid && bus.Z_ready;
      cur = {bus.Z1, bus.Z2, bus.Z3, bus.Z4, bus.Z_last};
      if (prev_stall && !prev_abort)
        check("hold_stable", bus.Z_valid && (cur == prev_data), int'(bus.Z1), int'(prev_data[4*DATA_W:3*DATA_W+1]));
      if (bus.Z_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.En_mem) begin
        check("credit", (outstanding - int'(pop)) < 2, outstanding - int'(pop), 1);
        check("addr_range", int'(bus.addr_mem) <= N - 1, int'(bus.addr_mem), N - 1);
      end
      if (pop) begin
        if (sb.size() == 0) begin
          check("extra_beat", 1'b0, beat_cnt + 1, beat_cnt);
        end else begin
          e = sb.pop_front();
          check("beat_data",
                int'(bus.Z1) == 16*e.addr+1 && int'(bus.Z2) == 16*e.addr+2 &&
                int'(bus.Z3) == 16*e.addr+3 && int'(bus.Z4) == 16*e.addr+4 &&
                bus.Z_last == e.last,
                int'(bus.Z1) * 2 + int'(bus.Z_last), (16*e.addr+1) * 2 + int'(e.last));
        end
        beat_cnt++;
        if (bus.Z_last) last_cnt++;
        if (beat_cnt == 1) begin first_z1 = int'(bus.Z1); first_beat_cyc = cyc; end
        last_z1       = int'(bus.Z1);
        last_beat_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      outstanding += int'(bus.En_mem) - int'(pop);
      if (abort && busy) outstanding = 0;
      prev_stall = bus.Z_valid && !bus.Z_ready;
      prev_data  = cur;
      prev_abort = abort;
    end
  end

  task automatic clear_stats();
    beat_cnt = 0; done_cnt = 0; last_cnt = 0;
    first_valid_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
    first_z1 = -1; last_z1 = -1;
    sb.delete();
  endtask

  task automatic push_pass(input int passes);
    for (int p = 0; p < passes; p++)
      for (int a = 0; a < N; a++) sb.push_back('{addr: a, last: (a == N - 1)});
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int mode);
    int  d0 = done_cnt;
    bit  ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      bus.Z_ready = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
      if (loop_drop && beat_cnt >= 20) loop_i = 1'b0;
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    check("done_seen", ok, ok, 1);
  endtask

  initial begin
    int go_cyc, d;
    bit ok, bad;
    #20000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int go_cyc, d;
    bit ok, bad;
    bus.Z_ready = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          !bus.En_mem && bus.addr_mem == 0 && !bus.Z_valid && bus.Z1 == 0 && bus.Z4 == 0 &&
          !bus.Z_last && !busy && !done && !bus.R_w_mem,
          {bus.En_mem, bus.Z_valid, bus.Z_last, busy, done}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic pass
    clear_stats(); push_pass(1); bus.Z_ready = 1'b1;
    go_cyc = cyc; pulse_go();
    wait_done(100, 0);
    check("first_valid_latency", first_valid_cyc == go_cyc + 3, first_valid_cyc - go_cyc, 3);
    check("basic_beats", beat_cnt == 8, beat_cnt, 8);
    check("basic_first_z1", first_z1 == 1, first_z1, 1);
    check("basic_last_z1", last_z1 == 113, last_z1, 113);
    check("basic_consecutive", last_beat_cyc - first_beat_cyc == 7, last_beat_cyc - first_beat_cyc, 7);
    check("basic_last_count", last_cnt == 1, last_cnt, 1);
    check("done_after_last", done_cyc == last_beat_cyc + 1, done_cyc - last_beat_cyc, 1);
    check("busy_low_after_done", !busy, busy, 0);

    // Backpressure 1,0,0,1
    clear_stats(); push_pass(1); bus.Z_ready = 1'b1;
    pulse_go();
    wait_done(200, 1);
    check("bp_beats", beat_cnt == 8, beat_cnt, 8);
    check("bp_sb_empty", sb.size() == 0, sb.size(), 0);

    // Loop mode for three passes
    clear_stats(); push_pass(3); bus.Z_ready = 1'b1;
    loop_i = 1'b1; loop_drop = 1'b1;
    pulse_go();
    wait_done(300, 0);
    loop_drop = 1'b0; loop_i = 1'b0;
    check("loop_beats", beat_cnt == 24, beat_cnt, 24);
    check("loop_last_count", last_cnt == 3, last_cnt, 3);
    check("loop_single_done", done_cnt == 1, done_cnt, 1);

    // Abort during stall at beat 3
    clear_stats(); push_pass(1); bus.Z_ready = 1'b1;
    pulse_go();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (beat_cnt >= 2) begin
        bus.Z_ready = 1'b0;
        if (bus.Z_valid) begin abort = 1'b1; ok = 1'b1; break; end
      end
      @(posedge clk); #1;
    end
    check("abort_reached", ok, ok, 1);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid_low", !bus.Z_valid, bus.Z_valid, 0);
    check("abort_busy_low", !busy, busy, 0);
    d = done_cnt;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt == d && !bus.Z_valid, done_cnt - d, 0);
    clear_stats(); push_pass(1); bus.Z_ready = 1'b1;
    pulse_go();
    wait_done(100, 0);
    check("restart_first_z1", first_z1 == 1, first_z1, 1);
    check("restart_beats", beat_cnt == 8, beat_cnt, 8);

    // GO while busy
    clear_stats(); push_pass(1); bus.Z_ready = 1'b1;
    pulse_go();
    for (int i = 0; i < 100 && beat_cnt < 3; i++) begin @(posedge clk); #1; end
    pulse_go();
    wait_done(100, 0);
    repeat (4) @(posedge clk);
    #1;
    check("gobusy_beats", beat_cnt == 8, beat_cnt, 8);
    check("gobusy_done_count", done_cnt == 1, done_cnt, 1);
    check("gobusy_idle", !busy && !bus.Z_valid, busy, 0);

    // Asynchronous reset mid-stream
    clear_stats(); push_pass(1); bus.Z_ready = 1'b1;
    pulse_go();
    for (int i = 0; i < 100 && beat_cnt < 4; i++) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          !bus.En_mem && bus.addr_mem == 0 && !bus.Z_valid && bus.Z1 == 0 &&
          !bus.Z_last && !busy && !done,
          {bus.En_mem, bus.Z_valid, bus.Z_last, busy, done}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy || bus.Z_valid || bus.En_mem) bad = 1'b1;
    end
    check("idle_after_reset", !bad, bad, 0);
    clear_stats(); push_pass(1); bus.Z_ready = 1'b1;
    pulse_go();
    wait_done(100, 0);
    check("post_reset_beats", beat_cnt == 8, beat_cnt, 8);
    check("post_reset_first_z1", first_z1 == 1, first_z1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
